// File: rtl/lbist_if.sv
// LBIST controller bus: run control, CUT drive/response and result.
interface lbist_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] resp_in;
    logic [WIDTH-1:0] pat_out;
    logic             pat_valid;
    logic             busy;
    logic             done;
    logic             pass;
    logic [WIDTH-1:0] signature;

    modport master (
        output start, resp_in,
        input  pat_out, pat_valid, busy, done, pass, signature
    );

    modport slave (
        input  start, resp_in,
        output pat_out, pat_valid, busy, done, pass, signature
    );
endinterface

// File: rtl/lbist_controller.sv
// Logic BIST controller: LFSR pattern source, MISR response compactor,
// golden-signature compare after a fixed pattern count.
module lbist_controller #(
    parameter int               WIDTH  = 8,
    parameter logic [WIDTH-1:0] TAPS   = 'hB8,
    parameter logic [WIDTH-1:0] SEED   = 'h01,
    parameter int               NPAT   = 255,
    parameter int               LAT    = 0,
    parameter logic [WIDTH-1:0] GOLDEN = 'h00
) (
    input logic   C,
    input logic   R,
    lbist_if.slave bus
);
    localparam int RUNLEN = NPAT + LAT;
    localparam int CW     = $clog2(RUNLEN + 1);

    localparam logic [WIDTH-1:0] SEED_V = (SEED == '0) ? WIDTH'(1) : SEED;
    localparam logic [CW-1:0]    LAST   = CW'(RUNLEN - 1);
    localparam logic [CW-1:0]    NPAT_C = CW'(NPAT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEED,
        S_RUN,
        S_CMP,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [WIDTH-1:0] misr_q, misr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             pass_q, pass_d;
    logic             pat_vld;
    logic             cap;

    function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] v);
        return {v[WIDTH-2:0], ^(v & TAPS)};
    endfunction

    // With one cycle of CUT latency the first RUN cycle has nothing to capture.
    assign pat_vld = (state_q == S_RUN) && (cnt_q < NPAT_C);
    assign cap     = (state_q == S_RUN) && ((LAT == 0) || (cnt_q != '0));

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        misr_d  = misr_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) state_d = S_SEED;
            end
            S_SEED: begin
                lfsr_d  = SEED_V;
                misr_d  = '0;
                cnt_d   = '0;
                pass_d  = 1'b0;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (pat_vld) lfsr_d = step(lfsr_q);
                if (cap) misr_d = step(misr_q) ^ bus.resp_in;
                if (cnt_q == LAST) state_d = S_CMP;
                else cnt_d = cnt_q + 1'b1;
            end
            S_CMP: begin
                pass_d  = (misr_q == GOLDEN);
                state_d = S_DONE;
            end
            S_DONE: begin
                if (bus.start) state_d = S_SEED;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge C or posedge R) begin
        if (R) begin
            state_q <= S_IDLE;
            lfsr_q  <= '0;
            misr_q  <= '0;
            cnt_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            misr_q  <= misr_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
        end
    end

    assign bus.pat_out   = lfsr_q;
    assign bus.pat_valid = pat_vld;
    assign bus.busy      = (state_q == S_SEED) || (state_q == S_RUN)
                        || (state_q == S_CMP);
    assign bus.done      = (state_q == S_DONE);
    assign bus.pass      = pass_q;
    assign bus.signature = misr_q;
endmodule
